// File: rtl/vga_101.sv
// VGA snake game: 640x480@60 timing from a 1-in-4 pixel enable, an 8-segment
// snake on a 40x30 grid of 16x16 cells, steered by two active-low buttons.
module vga_101 (
  input  logic       CLK_100MHz,
  input  logic       ResetN,
  input  logic       SwitchLeft,
  input  logic       SwitchRight,
  output logic       HSync,
  output logic       VSync,
  output logic [2:0] Red,
  output logic [2:0] Green,
  output logic [1:0] Blue
);

  // state   | meaning
  // ST_PLAY | snake advances on every move tick
  // ST_OVER | head hit the body; snake frozen until reset
  typedef enum logic {ST_PLAY, ST_OVER} game_state_t;

  localparam logic [1:0] TURN_NONE = 2'd0;
  localparam logic [1:0] TURN_CCW  = 2'd1;
  localparam logic [1:0] TURN_CW   = 2'd2;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  logic [1:0]  div;
  logic        pen;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [2:0]  frame_cnt;
  logic        frame_tick;
  logic        move_tick;

  logic [1:0]  left_sync;
  logic [1:0]  right_sync;
  logic        left_prev;
  logic        right_prev;
  logic        left_press;
  logic        right_press;
  logic        press_one;
  logic [1:0]  turn_press;
  logic [1:0]  pending;

  game_state_t state_q;
  game_state_t state_d;
  logic        advance;
  logic        game_over;

  logic [1:0]  dir;
  logic [1:0]  dir_next;
  logic [5:0]  seg_x [8];
  logic [4:0]  seg_y [8];
  logic [5:0]  head_x_next;
  logic [4:0]  head_y_next;
  logic        hit;

  logic [5:0]  cx;
  logic [4:0]  cy;
  logic        visible;
  logic        head_on;
  logic        body_on;

  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN) div <= 2'd0;
    else         div <= div + 2'd1;
  end

  assign pen = (div == 2'd3);

  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pen) begin
      if (h_cnt == 10'd799) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Game state only changes at the first blanking line, so a frame never tears.
  assign frame_tick = pen && (h_cnt == 10'd0) && (v_cnt == 10'd480);
  assign move_tick  = frame_tick && (frame_cnt == 3'd7);

  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN)         frame_cnt <= 3'd0;
    else if (frame_tick) frame_cnt <= frame_cnt + 3'd1;
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN) begin
      left_sync  <= 2'b11;
      right_sync <= 2'b11;
      left_prev  <= 1'b1;
      right_prev <= 1'b1;
    end else begin
      left_sync  <= {left_sync[0], SwitchLeft};
      right_sync <= {right_sync[0], SwitchRight};
      left_prev  <= left_sync[1];
      right_prev <= right_sync[1];
    end
  end

  assign left_press  = left_prev & ~left_sync[1];
  assign right_press = right_prev & ~right_sync[1];
  assign press_one   = left_press ^ right_press;
  assign turn_press  = left_press ? TURN_CCW : TURN_CW;

  // A press landing on the move tick itself is kept for the following tick.
  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN)        pending <= TURN_NONE;
    else if (move_tick) pending <= press_one ? turn_press : TURN_NONE;
    else if (press_one) pending <= turn_press;
  end

  always_comb begin
    dir_next = dir;
    case (pending)
      TURN_CCW: dir_next = dir + 2'd1;
      TURN_CW:  dir_next = dir - 2'd1;
      default:  dir_next = dir;
    endcase
  end

  always_comb begin
    head_x_next = seg_x[0];
    head_y_next = seg_y[0];
    case (dir_next)
      DIR_RIGHT: head_x_next = (seg_x[0] == 6'd39) ? 6'd0 : seg_x[0] + 6'd1;
      DIR_UP:    head_y_next = (seg_y[0] == 5'd0) ? 5'd29 : seg_y[0] - 5'd1;
      DIR_LEFT:  head_x_next = (seg_x[0] == 6'd0) ? 6'd39 : seg_x[0] - 6'd1;
      DIR_DOWN:  head_y_next = (seg_y[0] == 5'd29) ? 5'd0 : seg_y[0] + 5'd1;
      default:   head_x_next = seg_x[0];
    endcase
  end

  // The old tail is vacated by this move, so it is excluded from the hit test.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if ((seg_x[i] == head_x_next) && (seg_y[i] == head_y_next)) hit = 1'b1;
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN) state_q <= ST_PLAY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (move_tick) begin
          advance = 1'b1;
          if (hit) state_d = ST_OVER;
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_PLAY;
    endcase
  end

  assign game_over = (state_q == ST_OVER);

  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN) begin
      dir <= DIR_RIGHT;
      for (int i = 0; i < 8; i++) begin
        seg_x[i] <= 6'(20 - i);
        seg_y[i] <= 5'd15;
      end
    end else if (advance) begin
      dir      <= dir_next;
      seg_x[0] <= head_x_next;
      seg_y[0] <= head_y_next;
      for (int i = 1; i < 8; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
    end
  end

  assign cx      = h_cnt[9:4];
  assign cy      = v_cnt[8:4];
  assign visible = (h_cnt < 10'd640) && (v_cnt < 10'd480);
  assign head_on = (cx == seg_x[0]) && (cy == seg_y[0]);

  always_comb begin
    body_on = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if ((cx == seg_x[i]) && (cy == seg_y[i])) body_on = 1'b1;
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!ResetN) begin
      HSync <= 1'b1;
      VSync <= 1'b1;
      Red   <= 3'd0;
      Green <= 3'd0;
      Blue  <= 2'd0;
    end else if (pen) begin
      HSync <= !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
      VSync <= !((v_cnt == 10'd490) || (v_cnt == 10'd491));
      if (!visible) begin
        {Red, Green, Blue} <= 8'h00;
      end else if (head_on) begin
        {Red, Green, Blue} <= {3'd7, 3'd7, 2'd3};
      end else if (body_on) begin
        {Red, Green, Blue} <= game_over ? {3'd7, 3'd0, 2'd0} : {3'd0, 3'd7, 2'd0};
      end else begin
        {Red, Green, Blue} <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_vga_101.sv
// Directed bench for vga_101: sync timing, rendering tables and game sequences.
// Long waits are skipped by depositing the timing counters between clock edges.
`timescale 1ns/1ps
module tb_vga_101;

  logic       clk;
  logic       rst_n;
  logic       sw_left;
  logic       sw_right;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] C_WHITE = 8'hFF;
  localparam logic [7:0] C_GREEN = 8'h1C;
  localparam logic [7:0] C_RED   = 8'hE0;
  localparam logic [7:0] C_BLACK = 8'h00;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] rgb;
  } pix_vec_t;

  pix_vec_t init_vecs [9];

  vga_101 dut (
    .CLK_100MHz (clk),
    .ResetN     (rst_n),
    .SwitchLeft (sw_left),
    .SwitchRight(sw_right),
    .HSync      (hsync),
    .VSync      (vsync),
    .Red        (red),
    .Green      (green),
    .Blue       (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Position the counters so the output register shows pixel (x, y) after one pen.
  task automatic goto_pixel(input int x, input int y);
    @(negedge clk);
    dut.h_cnt = 10'(x);
    dut.v_cnt = 10'(y);
    dut.div   = 2'd0;
  endtask

  task automatic pixel(input string name, input int x, input int y, input logic [7:0] exp);
    goto_pixel(x, y);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check(name, {24'd0, red, green, blue}, {24'd0, exp});
  endtask

  task automatic do_move();
    @(negedge clk);
    dut.frame_cnt = 3'd7;
    dut.h_cnt     = 10'd0;
    dut.v_cnt     = 10'd480;
    dut.div       = 2'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic left, input logic right);
    @(negedge clk);
    sw_left  = ~left;
    sw_right = ~right;
    repeat (100) @(posedge clk);
    @(negedge clk);
    sw_left  = 1'b1;
    sw_right = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    int cnt;
    int n;

    init_vecs[0] = '{320, 240, C_WHITE};
    init_vecs[1] = '{335, 255, C_WHITE};
    init_vecs[2] = '{304, 240, C_GREEN};
    init_vecs[3] = '{208, 240, C_GREEN};
    init_vecs[4] = '{192, 240, C_BLACK};
    init_vecs[5] = '{336, 240, C_BLACK};
    init_vecs[6] = '{0,   0,   C_BLACK};
    init_vecs[7] = '{320, 256, C_BLACK};
    init_vecs[8] = '{320, 239, C_BLACK};

    rst_n    = 1'b1;
    sw_left  = 1'b1;
    sw_right = 1'b1;

    // Reset values appear on the first clock with ResetN low.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_hsync", {31'd0, hsync}, 32'd1);
    check("reset_vsync", {31'd0, vsync}, 32'd1);
    check("reset_rgb", {24'd0, red, green, blue}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First HSync fall: pixel 656 is registered on the 657th pen.
    cnt = 0;
    while (cnt < 4000) begin
      @(posedge clk); #1;
      cnt++;
      if (!hsync) break;
    end
    check("hsync_first_fall_near_2628", {31'd0, (cnt >= 2620 && cnt <= 2636)}, 32'd1);

    n = 0;
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (hsync) break;
    end
    check("hsync_low_clocks", 32'(n), 32'd384);
    while (n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (!hsync) break;
    end
    check("hsync_period_clocks", 32'(n), 32'd3200);

    goto_pixel(790, 489);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!vsync) break;
    end
    check("vsync_fall_seen", {31'd0, vsync}, 32'd0);
    n = 0;
    while (n < 8000) begin
      @(posedge clk); #1;
      n++;
      if (vsync) break;
    end
    check("vsync_low_clocks", 32'(n), 32'd6400);

    for (int i = 0; i < 9; i++) begin
      pixel($sformatf("init_pix[%0d]", i), init_vecs[i].h, init_vecs[i].v, init_vecs[i].rgb);
    end

    // One move right, then wrap from x = 39 to x = 0.
    do_reset();
    do_move();
    pixel("move1_head", 336, 240, C_WHITE);
    pixel("move1_neck", 320, 240, C_GREEN);
    pixel("move1_tail", 224, 240, C_GREEN);
    pixel("move1_old_tail", 208, 240, C_BLACK);
    repeat (18) do_move();
    pixel("head_at_x39", 624, 240, C_WHITE);
    do_move();
    pixel("wrap_head_x0", 0, 240, C_WHITE);
    pixel("wrap_neck_x39", 624, 240, C_GREEN);

    do_reset();
    press(1'b1, 1'b0);
    do_move();
    pixel("left_turn_head", 320, 224, C_WHITE);
    pixel("left_turn_neck", 320, 240, C_GREEN);

    do_reset();
    press(1'b0, 1'b1);
    do_move();
    pixel("right_turn_head", 320, 256, C_WHITE);

    do_reset();
    press(1'b1, 1'b1);
    do_move();
    pixel("both_cancel_head", 336, 240, C_WHITE);

    do_reset();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    do_move();
    pixel("override_head", 320, 256, C_WHITE);
    pixel("override_not_up", 320, 224, C_BLACK);

    // Up, left, down drives the head back onto (19, 15).
    do_reset();
    press(1'b1, 1'b0);
    do_move();
    press(1'b1, 1'b0);
    do_move();
    press(1'b1, 1'b0);
    do_move();
    pixel("collide_head", 304, 240, C_WHITE);
    pixel("collide_body_20_15", 320, 240, C_RED);
    pixel("collide_body_19_14", 304, 224, C_RED);
    do_move();
    pixel("frozen_head", 304, 240, C_WHITE);
    pixel("frozen_not_moved", 304, 256, C_BLACK);
    pixel("frozen_body_18_15", 288, 240, C_RED);

    do_reset();
    check("midreset_hsync", {31'd0, hsync}, 32'd1);
    check("midreset_rgb", {24'd0, red, green, blue}, 32'd0);
    pixel("midreset_head", 320, 240, C_WHITE);
    pixel("midreset_body_green", 304, 240, C_GREEN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
